// File: rtl/instr_seq_pkg.sv
// Purpose: shared types and constants for the instruction sequencer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Default instruction geometry: opcode lives in the top nibble.
  localparam int DEF_INSTR_WIDTH = 20;
  localparam int OPC_W           = 4;
  localparam int OPC_MSB         = DEF_INSTR_WIDTH - 1;

  localparam logic [OPC_W-1:0]           DEF_HALT_OPCODE = 4'hF;
  localparam logic [DEF_INSTR_WIDTH-1:0] DEF_NOP_INSTR   = 20'h00000;

endpackage

// File: rtl/instr_store.sv
// Purpose: register-array instruction memory, synchronous write, combinational read.
// Latency: write visible on the edge after we_i; read is same-cycle.
// Backpressure: none; every write is accepted.
module instr_store #(
  parameter int WIDTH = 20,
  parameter int AW    = 5
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  // Program contents survive reset on purpose so a run can be restarted.
  logic [WIDTH-1:0] mem_q [2**AW];

  // Synchronous write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_sequencer.sv
// Purpose: loads a program, then issues one instruction at a time to the CPU, each held CYCLES_PER_INSTR cycles.
// Latency: first instruction on instr_out one cycle after start is sampled; back-to-back thereafter.
// Backpressure: none toward the CPU; host must watch busy (start/prog_we ignored outside IDLE). Option macro: SINGLE_STEP_EN.
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int                       INSTR_WIDTH      = DEF_INSTR_WIDTH,
  parameter int                       PC_BITS          = 5,
  parameter int                       CYCLES_PER_INSTR = 3,
  parameter logic [INSTR_WIDTH-1:0]   NOP_INSTR        = INSTR_WIDTH'(DEF_NOP_INSTR),
  parameter logic [OPC_W-1:0]         HALT_OPCODE      = DEF_HALT_OPCODE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   prog_we,
  input  logic [PC_BITS-1:0]     prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  input  logic [PC_BITS:0]       prog_len,
  input  logic                   start,
`ifdef SINGLE_STEP_EN
  input  logic                   step,
`endif
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic                   instr_valid,
  output logic [PC_BITS-1:0]     pc,
  output logic                   busy,
  output logic                   done,
  output logic                   halted
);

  localparam int               CNT_W    = (CYCLES_PER_INSTR > 1) ? $clog2(CYCLES_PER_INSTR) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_INSTR - 1);

  state_e                   state_q, state_d;
  logic [PC_BITS-1:0]       pc_q, pc_d;
  logic [PC_BITS:0]         len_q, len_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
  logic                     vld_q, vld_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     halted_q, halted_d;
`ifdef SINGLE_STEP_EN
  logic                     wait_q, wait_d;
`endif

  logic                     store_we;
  logic [PC_BITS-1:0]       fetch_addr;
  logic [INSTR_WIDTH-1:0]   rd_data;
  logic [INSTR_WIDTH-1:0]   fetch_word;
  logic                     fetch_halt;
  logic [PC_BITS:0]         pc_inc;
  logic                     do_fetch;

  assign store_we = prog_we && (state_q == IDLE);

  // pc+1 is one bit wider so a full 2^PC_BITS program ends without wrapping.
  assign pc_inc     = {1'b0, pc_q} + {{PC_BITS{1'b0}}, 1'b1};
  // The fetch looks ahead: the word is registered on the edge that opens its hold window.
  assign fetch_addr = (state_q == IDLE) ? '0 : pc_inc[PC_BITS-1:0];
  // A write landing on the same edge as start must still be seen by the first fetch.
  assign fetch_word = (store_we && (prog_addr == fetch_addr)) ? prog_data : rd_data;
  assign fetch_halt = (fetch_word[INSTR_WIDTH-1 -: OPC_W] == HALT_OPCODE);

  instr_store #(
    .WIDTH (INSTR_WIDTH),
    .AW    (PC_BITS)
  ) u_store (
    .clk_i   (clk),
    .we_i    (store_we),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .raddr_i (fetch_addr),
    .rdata_o (rd_data)
  );

  // Next-state and next-output decode for the IDLE/ISSUE/DONE controller.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    instr_d  = instr_q;
    vld_d    = vld_q;
    done_d   = 1'b0;
    halted_d = halted_q;
    do_fetch = 1'b0;
`ifdef SINGLE_STEP_EN
    wait_d   = wait_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          halted_d = 1'b0;
          if (prog_len == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            len_d    = prog_len;
            pc_d     = '0;
            state_d  = ISSUE;
            do_fetch = 1'b1;
          end
        end
      end

      ISSUE: begin
        if (halted_q) begin
          // The HALT slot has shown NOP for one cycle; wrap up now.
          state_d = DONE;
          done_d  = 1'b1;
`ifdef SINGLE_STEP_EN
        end else if (wait_q) begin
          if (step) begin
            wait_d   = 1'b0;
            do_fetch = 1'b1;
          end
`endif
        end else if (cnt_q == CNT_LAST) begin
          if (pc_inc == len_q) begin
            state_d = DONE;
            done_d  = 1'b1;
            instr_d = NOP_INSTR;
            vld_d   = 1'b0;
          end else begin
`ifdef SINGLE_STEP_EN
            wait_d  = 1'b1;
            instr_d = NOP_INSTR;
            vld_d   = 1'b0;
`else
            do_fetch = 1'b1;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A HALT word is never issued: NOP goes out and the run winds down.
    if (do_fetch) begin
      cnt_d = '0;
      if (fetch_halt) begin
        instr_d  = NOP_INSTR;
        vld_d    = 1'b0;
        halted_d = 1'b1;
      end else begin
        instr_d = fetch_word;
        vld_d   = 1'b1;
        pc_d    = fetch_addr;
      end
    end

    busy_d = (state_d == ISSUE);
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      instr_q  <= NOP_INSTR;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      halted_q <= 1'b0;
`ifdef SINGLE_STEP_EN
      wait_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      instr_q  <= instr_d;
      vld_q    <= vld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      halted_q <= halted_d;
`ifdef SINGLE_STEP_EN
      wait_q   <= wait_d;
`endif
    end
  end

  assign instr_out   = instr_q;
  assign instr_valid = vld_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Purpose: self-checking bench for instr_sequencer against a trace-level reference model.
// Latency: samples outputs 1ns after each rising edge.
// Backpressure: n/a. Builds with or without SINGLE_STEP_EN.
module tb_instr_sequencer;

  localparam int          CPI = 3;
  localparam logic [19:0] NOP = 20'h00000;

  logic        clk;
  logic        rst;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [19:0] prog_data;
  logic [5:0]  prog_len;
  logic        start;
`ifdef SINGLE_STEP_EN
  logic        step;
`endif
  logic [19:0] instr_out;
  logic        instr_valid;
  logic [4:0]  pc;
  logic        busy;
  logic        done;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected per-cycle observation; pc only meaningful while valid.
  typedef struct packed {
    logic [19:0] instr;
    logic        vld;
    logic [4:0]  pc;
    logic        busy;
    logic        done;
  } obs_t;

  logic [19:0] mem_m [32];
  obs_t        exp_q [$];
  logic        model_halted;

  instr_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_len    (prog_len),
    .start       (start),
`ifdef SINGLE_STEP_EN
    .step        (step),
`endif
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .done        (done),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int a, input logic [19:0] d);
    prog_we   = 1'b1;
    prog_addr = a[4:0];
    prog_data = d;
    tick();
    prog_we   = 1'b0;
    mem_m[a]  = d;
  endtask

  // Reference: walk the program, each word held CPI cycles, HALT gives one NOP slot, then a done cycle.
  task automatic build_model(input int len);
    exp_q.delete();
    model_halted = 1'b0;
    for (int i = 0; i < len; i++) begin
      logic [19:0] w;
      w = mem_m[i];
      if (w[19:16] == 4'hF) begin
        exp_q.push_back({NOP, 1'b0, 5'd0, 1'b1, 1'b0});
        model_halted = 1'b1;
        break;
      end
      for (int c = 0; c < CPI; c++) begin
        exp_q.push_back({w, 1'b1, 5'(i), 1'b1, 1'b0});
      end
    end
    exp_q.push_back({NOP, 1'b0, 5'd0, 1'b0, 1'b1});
  endtask

  task automatic run_prog(input string name, input int len, input bit disturb);
    build_model(len);
    prog_len = len[5:0];
    start    = 1'b1;
    tick();
    start    = 1'b0;
    prog_we  = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      obs_t ex;
      obs_t act;
      ex  = exp_q[i];
      act = {instr_out, instr_valid, (ex.vld ? pc : 5'd0), busy, done};
      n_checks++;
      if (act !== ex) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got instr=%h vld=%b pc=%0d busy=%b done=%b, expected instr=%h vld=%b pc=%0d busy=%b done=%b",
                 name, i, act.instr, act.vld, act.pc, act.busy, act.done,
                 ex.instr, ex.vld, ex.pc, ex.busy, ex.done);
      end
      if (i < exp_q.size() - 1) begin
        if (disturb) begin
          prog_we   = 1'b1;
          prog_addr = 5'd0;
          prog_data = 20'($urandom);
          start     = 1'($urandom_range(0, 1));
        end
        tick();
      end
    end
    prog_we = 1'b0;
    start   = 1'b0;
    n_checks++;
    if (halted !== model_halted) begin
      n_fail++;
      $display("FAIL %s halted: got %b expected %b", name, halted, model_halted);
    end
    tick();
    n_checks++;
    if ({busy, done, instr_valid, instr_out} !== {1'b0, 1'b0, 1'b0, NOP}) begin
      n_fail++;
      $display("FAIL %s idle_after: got busy=%b done=%b vld=%b instr=%h expected 0 0 0 %h",
               name, busy, done, instr_valid, instr_out, NOP);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({instr_out, instr_valid, pc, busy, done, halted} !== {NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got instr=%h vld=%b pc=%0d busy=%b done=%b halted=%b expected all zero",
               instr_out, instr_valid, pc, busy, done, halted);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic load_basic;
    load_word(0, 20'h1_0203);
    load_word(1, 20'h2_0405);
    load_word(2, 20'h3_0001);
  endtask

  task automatic test_basic;
    load_basic();
    run_prog("basic", 3, 1'b0);
  endtask

  task automatic test_halt;
    load_word(0, 20'h1_0001);
    load_word(1, 20'hF_0000);
    load_word(2, 20'h2_0002);
    run_prog("halt", 3, 1'b0);
  endtask

  task automatic test_zero_len;
    run_prog("zero_len", 0, 1'b0);
  endtask

  task automatic test_reset_mid_run;
    load_basic();
    prog_len = 6'd3;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if ({instr_out, pc, instr_valid} !== {20'h2_0405, 5'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_run_pos: got instr=%h pc=%0d vld=%b expected 20405 1 1", instr_out, pc, instr_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({instr_out, pc, busy, instr_valid} !== {NOP, 5'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_run_reset: got instr=%h pc=%0d busy=%b vld=%b expected %h 0 0 0",
               instr_out, pc, busy, instr_valid, NOP);
    end
    tick();
    run_prog("restart", 3, 1'b0);
  endtask

  task automatic test_busy_ignore;
    for (int a = 0; a < 32; a++) begin
      load_word(a, {4'($urandom_range(0, 14)), 16'($urandom)});
    end
    run_prog("full32", 32, 1'b1);
    run_prog("store_kept", 1, 1'b0);
  endtask

  task automatic test_write_on_start;
    load_basic();
    prog_we   = 1'b1;
    prog_addr = 5'd1;
    prog_data = 20'h5_ABCD;
    mem_m[1]  = 20'h5_ABCD;
    run_prog("write_on_start", 3, 1'b0);
  endtask

  task automatic test_random;
    for (int r = 0; r < 6; r++) begin
      int len;
      len = $urandom_range(0, 32);
      for (int a = 0; a < 32; a++) begin
        load_word(a, {4'($urandom_range(0, 14)), 16'($urandom)});
      end
      if ($urandom_range(0, 2) == 0) begin
        load_word($urandom_range(0, 31), {4'hF, 16'($urandom)});
      end
      run_prog("random", len, 1'b0);
    end
  endtask

`ifdef SINGLE_STEP_EN
  task automatic check_issue(input string name, input logic [19:0] w, input int p);
    n_checks++;
    if ({instr_out, instr_valid, pc, busy} !== {w, 1'b1, 5'(p), 1'b1}) begin
      n_fail++;
      $display("FAIL %s: got instr=%h vld=%b pc=%0d busy=%b expected %h 1 %0d 1",
               name, instr_out, instr_valid, pc, busy, w, p);
    end
  endtask

  task automatic check_wait(input string name);
    n_checks++;
    if ({instr_out, instr_valid, busy} !== {NOP, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL %s: got instr=%h vld=%b busy=%b expected %h 0 1",
               name, instr_out, instr_valid, busy, NOP);
    end
  endtask

  task automatic test_single_step;
    load_basic();
    prog_len = 6'd3;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    check_issue("step_pc0_c0", 20'h1_0203, 0);
    step = 1'b1;
    tick();
    step = 1'b0;
    check_issue("step_pc0_c1", 20'h1_0203, 0);
    tick();
    check_issue("step_pc0_c2", 20'h1_0203, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_wait("step_wait0");
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int k = 0; k < CPI; k++) begin
      check_issue("step_pc1", 20'h2_0405, 1);
      tick();
    end
    check_wait("step_wait1");
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int k = 0; k < CPI; k++) begin
      check_issue("step_pc2", 20'h3_0001, 2);
      tick();
    end
    n_checks++;
    if ({done, busy, instr_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL step_done: got done=%b busy=%b vld=%b expected 1 0 0", done, busy, instr_valid);
    end
    tick();
  endtask
`endif

  initial begin
    rst       = 1'b1;
    prog_we   = 1'b0;
    prog_addr = 5'd0;
    prog_data = 20'd0;
    prog_len  = 6'd0;
    start     = 1'b0;
`ifdef SINGLE_STEP_EN
    step      = 1'b0;
`endif
    test_reset();
    test_zero_len();
`ifdef SINGLE_STEP_EN
    test_single_step();
`else
    test_basic();
    test_halt();
    test_reset_mid_run();
    test_busy_ignore();
    test_write_on_start();
    test_random();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
